// File: rtl/cic_comp_pkg.sv
// CIC droop-compensation FIR: shared constants, coefficient table,
// FSM state type and output saturation helper.
package cic_comp_pkg;

    localparam int DATA_W     = 8;
    localparam int COEF_W     = 10;
    localparam int COEF_FRAC_W = 9;
    localparam int TAPS       = 15;
    localparam int NUM_UNIQUE = 8;
    localparam int ACC_W      = 22;

    // Half of the symmetric impulse response: h0..h7, mirrored as h6..h0.
    localparam logic signed [COEF_W-1:0] CIC_COMP_COEFS [0:NUM_UNIQUE-1] = '{
        -10'sd2, 10'sd3, 10'sd6, -10'sd10,
        -10'sd14, 10'sd34, 10'sd96, 10'sd286
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND
    } state_e;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(DATA_W-1)));

    function automatic logic signed [DATA_W-1:0] sat_data(
        input logic signed [ACC_W-1:0] v
    );
        if (v > SAT_HI) begin
            return SAT_HI[DATA_W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cic_comp_fir_mac.sv
// Multiply-accumulate unit: registered product, then accumulate.
// Ports: en (operands valid), clr (zero acc), a/b operands, sum (acc incl. last product).
module cic_comp_fir_mac #(
    parameter int A_W       = 9,
    parameter int B_W       = 10,
    parameter int ACC_WIDTH = 22
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        clr,
    input  logic signed [A_W-1:0]       a,
    input  logic signed [B_W-1:0]       b,
    output logic signed [ACC_WIDTH-1:0] sum
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]       prod_d, prod_q;
    logic                        vld_d, vld_q;
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q, addend;

    always_comb begin
        prod_d = en ? a * b : prod_q;
        vld_d  = en;
        addend = vld_q ? ACC_WIDTH'(prod_q) : '0;
        acc_d  = clr ? '0 : acc_q + addend;
        // Folds in the product still sitting in the pipeline register,
        // so the total is ready one cycle after the last operand.
        sum    = acc_q + addend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// 15-tap symmetric CIC compensation FIR with decimation by DEC.
// Ports: in/in_valid sample strobe, out/out_valid result strobe, busy, sticky overrun.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int COEF_WIDTH = COEF_W,
    parameter int COEF_FRAC  = COEF_FRAC_W,
    parameter int NUM_TAPS   = TAPS,
    parameter int DEC        = 2,
    parameter int ACC_WIDTH  = ACC_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         busy,
    output logic                         overrun
);

    localparam int PH_W  = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int DW1   = DATA_WIDTH + 1;
    localparam int MID   = NUM_TAPS / 2;
    localparam int K_W   = $clog2(MID + 1);
    localparam int IDX_W = $clog2(NUM_TAPS);

    state_e state_q, state_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic signed [DATA_WIDTH-1:0] d_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] d_d [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] out_q, out_d;
    logic out_valid_q, out_valid_d;
    logic overrun_q, overrun_d;

    logic accept, last_phase, start, mac_en;
    logic [IDX_W-1:0] k_lo, k_hi;
    logic signed [DW1-1:0]        pre;
    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [ACC_WIDTH-1:0]  sum, rnd, shifted;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_phase = (phase_q == PH_W'(DEC - 1));
    assign start      = accept && last_phase;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    k_d     = '0;
                end
            end
            MAC: begin
                if (k_q == K_W'(MID)) begin
                    state_d = ROUND;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Delay line, phase and overrun bookkeeping
    always_comb begin
        phase_d   = phase_q;
        d_d       = d_q;
        overrun_d = overrun_q;
        if (accept) begin
            phase_d = last_phase ? '0 : phase_q + 1'b1;
            d_d[0]  = in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                d_d[k] = d_q[k-1];
            end
        end
        if (in_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Folded operand: pair of mirrored taps, or the lone centre tap
    always_comb begin
        k_lo = IDX_W'(k_q);
        k_hi = IDX_W'(NUM_TAPS - 1) - k_lo;
        if (k_q == K_W'(MID)) begin
            pre = DW1'(d_q[k_lo]);
        end else begin
            pre = DW1'(d_q[k_lo]) + DW1'(d_q[k_hi]);
        end
        coef = CIC_COMP_COEFS[k_q];
    end

    // Output logic: round half toward +inf, then clip
    always_comb begin
        busy        = (state_q != IDLE);
        mac_en      = (state_q == MAC);
        rnd         = sum + ACC_WIDTH'(2**(COEF_FRAC - 1));
        shifted     = rnd >>> COEF_FRAC;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (state_q == ROUND) begin
            out_d       = sat_data(shifted);
            out_valid_d = 1'b1;
        end
    end

    cic_comp_fir_mac #(
        .A_W       (DW1),
        .B_W       (COEF_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .clr   (start),
        .a     (pre),
        .b     (coef),
        .sum   (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            phase_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            phase_q     <= phase_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            d_q         <= d_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: DEC=1 and DEC=2 instances
// checked against a direct 15-tap convolution model.
module tb_cic_comp_fir;

    localparam int H [15] = '{-2, 3, 6, -10, -14, 34, 96, 286,
                              96, 34, -14, -10, 6, 3, -2};
    localparam int IMP [15] = '{0, 0, 1, -1, -2, 4, 12, 36,
                                12, 4, -2, -1, 1, 0, 0};

    logic clk = 1'b0;
    logic reset;
    logic iv1, iv2;
    logic signed [7:0] in1, in2;
    logic ov1, ov2, busy1, busy2, orun1, orun2;
    logic signed [7:0] o1, o2;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int hist1[$];
    int hist2[$];
    int cnt2 = 0;

    always #5 clk = ~clk;

    cic_comp_fir #(.DEC(1)) u_dec1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in(in1),
        .out_valid(ov1), .out(o1), .busy(busy1), .overrun(orun1)
    );

    cic_comp_fir #(.DEC(2)) u_dec2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in(in2),
        .out_valid(ov2), .out(o2), .busy(busy2), .overrun(orun2)
    );

    function automatic int model(input int hq[$]);
        int acc = 0;
        int r;
        for (int j = 0; j < 15; j++) begin
            if (j < hq.size()) acc += H[j] * hq[j];
        end
        r = (acc + 256) >>> 9;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 1) ? ov1 : ov2;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 1) ? busy1 : busy2;
    endfunction

    function automatic logic get_orun(input int w);
        return (w == 1) ? orun1 : orun2;
    endfunction

    function automatic logic signed [7:0] get_o(input int w);
        return (w == 1) ? o1 : o2;
    endfunction

    task automatic drive(input int w, input logic vld, input int v);
        if (w == 1) begin
            iv1 = vld;
            in1 = 8'(v);
        end else begin
            iv2 = vld;
            in2 = 8'(v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hist1.delete();
        hist2.delete();
        cnt2 = 0;
    endtask

    // One accepted sample, observed for 16 clocks (bounded).
    task automatic run_sample(input int w, input int v, output int lat,
                              output int outv, output int bcnt, output int vcnt);
        lat  = -1;
        outv = 0;
        bcnt = 0;
        vcnt = 0;
        @(negedge clk);
        drive(w, 1'b1, v);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) drive(w, 1'b0, 0);
            if (get_ov(w) === 1'b1) begin
                vcnt++;
                if (lat < 0) begin
                    lat  = i;
                    outv = int'(get_o(w));
                end
            end
            if (get_busy(w) === 1'b1) bcnt++;
        end
        if (w == 1) begin
            hist1.push_front(v);
        end else begin
            hist2.push_front(v);
            cnt2++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int w = 1; w <= 2; w++) begin
            chk_cnt++;
            if (get_o(w) !== 8'sd0) $display("FAIL reset_out dut%0d got %0d want 0", w, get_o(w));
            else pass_cnt++;
            chk_cnt++;
            if (get_ov(w) !== 1'b0) $display("FAIL reset_valid dut%0d got %b want 0", w, get_ov(w));
            else pass_cnt++;
            chk_cnt++;
            if (get_busy(w) !== 1'b0) $display("FAIL reset_busy dut%0d got %b want 0", w, get_busy(w));
            else pass_cnt++;
            chk_cnt++;
            if (get_orun(w) !== 1'b0) $display("FAIL reset_overrun dut%0d got %b want 0", w, get_orun(w));
            else pass_cnt++;
        end
    endtask

    task automatic test_impulse_dec1();
        int lat, outv, bcnt, vcnt, exp;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            run_sample(1, (n == 0) ? 64 : 0, lat, outv, bcnt, vcnt);
            exp = model(hist1);
            chk_cnt++;
            if (lat !== 10) $display("FAIL imp_latency n=%0d got %0d want 10", n, lat);
            else pass_cnt++;
            chk_cnt++;
            if (outv !== exp) $display("FAIL imp_out n=%0d got %0d want %0d", n, outv, exp);
            else pass_cnt++;
            chk_cnt++;
            if (vcnt !== 1) $display("FAIL imp_pulses n=%0d got %0d want 1", n, vcnt);
            else pass_cnt++;
            chk_cnt++;
            if (bcnt !== 9) $display("FAIL imp_busy n=%0d got %0d want 9", n, bcnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_const_step_dec2();
        int lat, outv, bcnt, vcnt, v;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int n = 0; n < 40; n++) begin
                if (pass == 0) v = 100;
                else v = (n < 20) ? -128 : 127;
                run_sample(2, v, lat, outv, bcnt, vcnt);
                if (cnt2 % 2 == 0) begin
                    chk_cnt++;
                    if (lat !== 10 || vcnt !== 1)
                        $display("FAIL d2_timing p%0d n=%0d got lat %0d cnt %0d want 10 1", pass, n, lat, vcnt);
                    else pass_cnt++;
                    chk_cnt++;
                    if (outv !== model(hist2))
                        $display("FAIL d2_out p%0d n=%0d got %0d want %0d", pass, n, outv, model(hist2));
                    else pass_cnt++;
                end else begin
                    chk_cnt++;
                    if (vcnt !== 0) $display("FAIL d2_nophase p%0d n=%0d got %0d pulses want 0", pass, n, vcnt);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_random_dec2();
        int lat, outv, bcnt, vcnt, v;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            v = int'($urandom_range(255, 0)) - 128;
            run_sample(2, v, lat, outv, bcnt, vcnt);
            chk_cnt++;
            if (cnt2 % 2 == 0) begin
                if (lat !== 10 || outv !== model(hist2))
                    $display("FAIL rnd_out n=%0d got %0d at %0d want %0d at 10", n, outv, lat, model(hist2));
                else pass_cnt++;
            end else begin
                if (vcnt !== 0) $display("FAIL rnd_nophase n=%0d got %0d pulses want 0", n, vcnt);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_overrun();
        int lat, outv, bcnt, vcnt, a, b;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            run_sample(1, int'($urandom_range(255, 0)) - 128, lat, outv, bcnt, vcnt);
        end
        a = int'($urandom_range(120, 20));
        b = -a;
        lat = -1;
        outv = 0;
        vcnt = 0;
        @(negedge clk);
        drive(1, 1'b1, a);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) drive(1, 1'b0, 0);
            if (i == 4) begin
                chk_cnt++;
                if (busy1 !== 1'b1) $display("FAIL ovr_busy got %b want 1", busy1);
                else pass_cnt++;
                drive(1, 1'b1, b);
            end
            if (i == 5) begin
                drive(1, 1'b0, 0);
                chk_cnt++;
                if (orun1 !== 1'b1) $display("FAIL ovr_flag got %b want 1", orun1);
                else pass_cnt++;
            end
            if (ov1 === 1'b1) begin
                vcnt++;
                if (lat < 0) begin
                    lat = i;
                    outv = int'(o1);
                end
            end
        end
        hist1.push_front(a);
        chk_cnt++;
        if (lat !== 10 || vcnt !== 1)
            $display("FAIL ovr_timing got lat %0d cnt %0d want 10 1", lat, vcnt);
        else pass_cnt++;
        chk_cnt++;
        if (outv !== model(hist1)) $display("FAIL ovr_out got %0d want %0d", outv, model(hist1));
        else pass_cnt++;
        run_sample(1, int'($urandom_range(255, 0)) - 128, lat, outv, bcnt, vcnt);
        chk_cnt++;
        if (orun1 !== 1'b1) $display("FAIL ovr_sticky got %b want 1", orun1);
        else pass_cnt++;
        chk_cnt++;
        if (outv !== model(hist1)) $display("FAIL ovr_next got %0d want %0d", outv, model(hist1));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mac();
        int lat, outv, bcnt, vcnt;
        for (int n = 0; n < 15; n++) begin
            run_sample(1, 100, lat, outv, bcnt, vcnt);
        end
        chk_cnt++;
        if (outv !== model(hist1)) $display("FAIL rst_pre_out got %0d want %0d", outv, model(hist1));
        else pass_cnt++;
        chk_cnt++;
        if (orun1 !== 1'b1) $display("FAIL rst_pre_overrun got %b want 1", orun1);
        else pass_cnt++;
        @(negedge clk);
        drive(1, 1'b1, 100);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) drive(1, 1'b0, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_cnt++;
        if (o1 !== 8'sd0 || ov1 !== 1'b0 || busy1 !== 1'b0 || orun1 !== 1'b0)
            $display("FAIL rst_mid got out %0d v %b busy %b ovr %b want 0 0 0 0", o1, ov1, busy1, orun1);
        else pass_cnt++;
        vcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov1 === 1'b1) vcnt++;
        end
        chk_cnt++;
        if (vcnt !== 0) $display("FAIL rst_no_valid got %0d pulses want 0", vcnt);
        else pass_cnt++;
        hist1.delete();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1'b1, 100);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 1'b0, 0);
        for (int n = 0; n < 15; n++) begin
            run_sample(1, (n == 0) ? 64 : 0, lat, outv, bcnt, vcnt);
            chk_cnt++;
            if (outv !== IMP[n] || lat !== 10)
                $display("FAIL rst_impulse n=%0d got %0d at %0d want %0d at 10", n, outv, lat, IMP[n]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, outv, bcnt, vcnt, a, b;
        do_reset();
        a = int'($urandom_range(255, 0)) - 128;
        b = int'($urandom_range(255, 0)) - 128;
        lat = -1;
        outv = 0;
        vcnt = 0;
        @(negedge clk);
        drive(2, 1'b1, a);
        @(negedge clk);
        chk_cnt++;
        if (busy2 !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy2);
        else pass_cnt++;
        drive(2, 1'b1, b);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) drive(2, 1'b0, 0);
            if (ov2 === 1'b1) begin
                vcnt++;
                if (lat < 0) begin
                    lat = i;
                    outv = int'(o2);
                end
            end
        end
        hist2.push_front(a);
        hist2.push_front(b);
        cnt2 += 2;
        chk_cnt++;
        if (orun2 !== 1'b0) $display("FAIL b2b_overrun got %b want 0", orun2);
        else pass_cnt++;
        chk_cnt++;
        if (lat !== 10 || vcnt !== 1) $display("FAIL b2b_timing got lat %0d cnt %0d want 10 1", lat, vcnt);
        else pass_cnt++;
        chk_cnt++;
        if (outv !== model(hist2)) $display("FAIL b2b_out got %0d want %0d", outv, model(hist2));
        else pass_cnt++;
        run_sample(2, 50, lat, outv, bcnt, vcnt);
        chk_cnt++;
        if (vcnt !== 0) $display("FAIL b2b_phase got %0d pulses want 0", vcnt);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        test_reset();
        test_impulse_dec1();
        test_const_step_dec2();
        test_random_dec2();
        test_overrun();
        test_reset_mid_mac();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
